// File: rtl/lpm_pkg.sv
// Shared LPM definitions: entry layout, field width, words per entry and word-index type.
// The optional out_enq_last port of lpm_entry_serializer is enabled by defining SERIALIZER_LAST_EN.
package lpm_pkg;

    localparam int LPM_DATA_W = 32;
    localparam int LPM_NWORDS = 3;
    localparam int LPM_IDX_W  = (LPM_NWORDS > 1) ? $clog2(LPM_NWORDS) : 1;

    typedef logic [LPM_IDX_W-1:0] lpm_idx_t;

    // Field a sits in the LSBs so that word k is bits [k*DATA_W +: DATA_W].
    typedef struct packed {
        logic [LPM_DATA_W-1:0] c;
        logic [LPM_DATA_W-1:0] b;
        logic [LPM_DATA_W-1:0] a;
    } lpm_entry_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/lpm_entry_serializer.sv
// Pops wide LPM entries from an upstream FIFO and emits them word by word (a, b, c) into an enq sink.
// Define SERIALIZER_LAST_EN to add out_enq_last, flagging the final word of each entry.
module lpm_entry_serializer
    import lpm_pkg::*;
#(
    parameter int DATA_W = LPM_DATA_W,
    parameter int NWORDS = LPM_NWORDS
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     in_deq__RDY,
    input  logic [DATA_W*NWORDS-1:0] in_first,
    output logic                     in_deq__ENA,
    input  logic                     out_enq__RDY,
    output logic                     out_enq__ENA,
    output logic [DATA_W-1:0]        out_enq_v
`ifdef SERIALIZER_LAST_EN
    ,
    output logic                     out_enq_last
`endif
);

    localparam int               IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    ser_state_t                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DATA_W*NWORDS-1:0]   hold_q, hold_d;

    logic                       busy;
    logic                       at_last;
    logic                       out_fire;
    logic                       in_fire;
    logic [DATA_W-1:0]          words [NWORDS];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            assign words[gi] = hold_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign busy    = (state_q == SER_SEND);
    assign at_last = (idx_q == LAST_IDX);

    // A refill is allowed while idle or while the final word leaves, which removes the inter-entry bubble.
    assign out_fire = nRST & busy & out_enq__RDY;
    assign in_fire  = nRST & in_deq__RDY & (~busy | (out_enq__RDY & at_last));

    assign in_deq__ENA  = in_fire;
    assign out_enq__ENA = out_fire;

    always_comb begin
        out_enq_v = words[0];
        for (int k = 1; k < NWORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                out_enq_v = words[k];
            end
        end
    end

`ifdef SERIALIZER_LAST_EN
    assign out_enq_last = busy & at_last;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (in_fire) begin
            state_d = SER_SEND;
            idx_d   = '0;
            hold_d  = in_first;
        end else if (out_fire) begin
            if (at_last) begin
                state_d = SER_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_lpm_entry_serializer.sv
// Bench for lpm_entry_serializer: directed scenarios plus a randomized run against a word-queue model.
module tb_lpm_entry_serializer;
    import lpm_pkg::*;

    localparam int W  = LPM_DATA_W;
    localparam int EW = LPM_DATA_W * LPM_NWORDS;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          in_rdy;
    logic [EW-1:0] in_first;
    logic          in_ena;
    logic          out_rdy;
    logic          out_ena;
    logic [W-1:0]  out_v;
    logic          out_last;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    lpm_entry_serializer dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_deq__RDY  (in_rdy),
        .in_first     (in_first),
        .in_deq__ENA  (in_ena),
        .out_enq__RDY (out_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v)
`ifdef SERIALIZER_LAST_EN
        ,
        .out_enq_last (out_last)
`endif
    );

`ifndef SERIALIZER_LAST_EN
    assign out_last = 1'b0;
`endif

    function automatic logic [EW-1:0] mk(input logic [W-1:0] c, input logic [W-1:0] b, input logic [W-1:0] a);
        lpm_entry_t e;
        e.c = c;
        e.b = b;
        e.a = a;
        return e;
    endfunction

    function automatic logic [EW-1:0] rnd_entry();
        return mk($urandom, $urandom, $urandom);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; in_rdy = 1'b1; out_rdy = 1'b1; in_first = mk(3, 2, 1);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ena !== 1'b0) begin errors++; $display("FAIL reset_in_ena: got %b want 0", in_ena); end
            checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL reset_out_ena: got %b want 0", out_ena); end
            tick();
        end
        nRST = 1'b1; in_rdy = 1'b0;
        #1;
        checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL post_reset_out_ena: got %b want 0", out_ena); end
        checks++; if (out_v !== '0) begin errors++; $display("FAIL post_reset_v: got %h want 0", out_v); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL post_reset_last: got %b want 0", out_last); end
        $display("reset: done");
        tick();
    endtask

    // Pops one entry, then checks its words and the per-word flags in order.
    task automatic test_single(input string name, input logic [W-1:0] c, input logic [W-1:0] b, input logic [W-1:0] a);
        logic [W-1:0] exp_w [3];
        exp_w[0] = a; exp_w[1] = b; exp_w[2] = c;
        in_rdy = 1'b1; in_first = mk(c, b, a); out_rdy = 1'b1;
        #1;
        checks++; if (in_ena !== 1'b1) begin errors++; $display("FAIL %s_pop: in_deq__ENA=%b want 1", name, in_ena); end
        checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL %s_early: out_enq__ENA=%b want 0", name, out_ena); end
        tick();
        in_rdy = 1'b0; in_first = rnd_entry();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_ena !== 1'b1) begin errors++; $display("FAIL %s_ena%0d: got %b want 1", name, k, out_ena); end
            checks++; if (out_v !== exp_w[k]) begin errors++; $display("FAIL %s_word%0d: got %h want %h", name, k, out_v, exp_w[k]); end
            checks++; if (in_ena !== 1'b0) begin errors++; $display("FAIL %s_nopop%0d: got %b want 0", name, k, in_ena); end
`ifdef SERIALIZER_LAST_EN
            checks++; if (out_last !== (k == 2)) begin errors++; $display("FAIL %s_last%0d: got %b want %b", name, k, out_last, (k == 2)); end
`endif
            $display("%s: word %0d = %h", name, k, out_v);
            tick();
        end
        #1;
        checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL %s_idle: out_enq__ENA=%b want 0", name, out_ena); end
        tick();
    endtask

    task automatic test_back_to_back();
        in_rdy = 1'b1; in_first = mk(3, 2, 1); out_rdy = 1'b1;
        #1;
        checks++; if (in_ena !== 1'b1) begin errors++; $display("FAIL b2b_pop0: got %b want 1", in_ena); end
        tick();
        in_first = mk(6, 5, 4);
        for (int k = 1; k <= 6; k++) begin
            in_rdy = (k <= 3);
            #1;
            checks++; if (out_ena !== 1'b1) begin errors++; $display("FAIL b2b_ena%0d: got %b want 1", k, out_ena); end
            checks++; if (out_v !== W'(k)) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", k, out_v, W'(k)); end
            checks++; if (in_ena !== (k == 3)) begin errors++; $display("FAIL b2b_pop%0d: got %b want %b", k, in_ena, (k == 3)); end
            $display("b2b: word %h", out_v);
            tick();
        end
        in_rdy = 1'b0;
        #1;
        checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", out_ena); end
        tick();
    endtask

    task automatic test_backpressure();
        in_rdy = 1'b1; in_first = mk(32'h33, 32'hDEADBEEF, 32'h11); out_rdy = 1'b1;
        tick();
        in_rdy = 1'b0;
        #1;
        checks++; if (out_v !== 32'h11) begin errors++; $display("FAIL bp_word_a: got %h want 11", out_v); end
        tick();
        in_rdy = 1'b1; in_first = rnd_entry(); out_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (out_v !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold%0d: got %h want deadbeef", c, out_v); end
            checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL bp_ena%0d: got %b want 0", c, out_ena); end
            checks++; if (in_ena !== 1'b0) begin errors++; $display("FAIL bp_pop%0d: got %b want 0", c, in_ena); end
            $display("bp: stalled on %h", out_v);
            tick();
        end
        in_rdy = 1'b0; out_rdy = 1'b1;
        #1;
        checks++; if (out_ena !== 1'b1 || out_v !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_resume_b: ena=%b v=%h want 1/deadbeef", out_ena, out_v); end
        tick();
        #1;
        checks++; if (out_ena !== 1'b1 || out_v !== 32'h33) begin errors++; $display("FAIL bp_resume_c: ena=%b v=%h want 1/33", out_ena, out_v); end
        tick();
    endtask

    task automatic test_empty_upstream();
        nRST = 1'b0; in_rdy = 1'b0; out_rdy = 1'b1;
        tick();
        nRST = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_first = rnd_entry(); out_rdy = 1'($urandom);
            #1;
            checks++; if (in_ena !== 1'b0 || out_ena !== 1'b0 || out_last !== 1'b0) begin
                errors++; $display("FAIL empty%0d: deq=%b enq=%b last=%b want 0/0/0", c, in_ena, out_ena, out_last);
            end
            tick();
        end
        $display("empty: 20 idle cycles");
    endtask

    task automatic test_reset_mid_entry();
        in_rdy = 1'b1; in_first = mk(32'hC, 32'hB, 32'hA); out_rdy = 1'b1;
        tick();
        in_rdy = 1'b0;
        #1;
        checks++; if (out_v !== 32'hA || out_ena !== 1'b1) begin errors++; $display("FAIL rst_mid_a: v=%h ena=%b want a/1", out_v, out_ena); end
        tick();
        nRST = 1'b0; in_rdy = 1'b1; in_first = mk(9, 8, 7);
        #1;
        checks++; if (out_ena !== 1'b0 || in_ena !== 1'b0) begin errors++; $display("FAIL rst_mid_gate: enq=%b deq=%b want 0/0", out_ena, in_ena); end
        tick();
        nRST = 1'b1;
        #1;
        checks++; if (out_ena !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: enq=%b want 0", out_ena); end
        checks++; if (in_ena !== 1'b1) begin errors++; $display("FAIL rst_mid_pop: deq=%b want 1", in_ena); end
        tick();
        in_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (out_ena !== 1'b1 || out_v !== W'(7 + k)) begin
                errors++; $display("FAIL rst_mid_word%0d: ena=%b v=%h want 1/%h", k, out_ena, out_v, W'(7 + k));
            end
            $display("rst_mid: word %h", out_v);
            tick();
        end
    endtask

    // Model: a 2-deep source FIFO and a queue of words still owed downstream.
    task automatic test_random();
        logic [EW-1:0] src_q [$];
        logic [W-1:0]  exp_q [$];
        logic [EW-1:0] e;
        logic          exp_out, exp_in;
        nRST = 1'b0; in_rdy = 1'b0; out_rdy = 1'b0;
        tick();
        nRST = 1'b1;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 380 && src_q.size() < 2 && $urandom_range(0, 2) != 0) src_q.push_back(rnd_entry());
            in_rdy   = (src_q.size() > 0);
            in_first = in_rdy ? src_q[0] : rnd_entry();
            out_rdy  = (cyc >= 380) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            exp_out = out_rdy && (exp_q.size() > 0);
            exp_in  = in_rdy && ((exp_q.size() == 0) || (exp_q.size() == 1 && out_rdy));
            checks++; if (out_ena !== exp_out) begin errors++; $display("FAIL rand_enq_ena@%0d: got %b want %b", cyc, out_ena, exp_out); end
            checks++; if (in_ena !== exp_in) begin errors++; $display("FAIL rand_deq_ena@%0d: got %b want %b", cyc, in_ena, exp_in); end
            if (out_ena === 1'b1 && exp_q.size() > 0) begin
                checks++; if (out_v !== exp_q[0]) begin errors++; $display("FAIL rand_word@%0d: got %h want %h", cyc, out_v, exp_q[0]); end
`ifdef SERIALIZER_LAST_EN
                checks++; if (out_last !== (exp_q.size() == 1)) begin errors++; $display("FAIL rand_last@%0d: got %b want %b", cyc, out_last, (exp_q.size() == 1)); end
`endif
                $display("rand: cycle %0d word %h", cyc, out_v);
                void'(exp_q.pop_front());
            end
            if (in_ena === 1'b1 && src_q.size() > 0) begin
                e = src_q.pop_front();
                for (int k = 0; k < LPM_NWORDS; k++) exp_q.push_back(e[k*W +: W]);
            end
            tick();
        end
        checks++; if (exp_q.size() != 0 || src_q.size() != 0) begin
            errors++; $display("FAIL rand_drain: words_left=%0d entries_left=%0d want 0/0", exp_q.size(), src_q.size());
        end
        in_rdy = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; in_rdy = 1'b0; in_first = '0; out_rdy = 1'b0;
        test_reset();
        test_single("single", 32'd3, 32'd2, 32'd1);
        test_back_to_back();
        test_backpressure();
        test_empty_upstream();
        test_reset_mid_entry();
        test_single("slicing", 32'hFFFFFFFF, 32'h0, 32'h80000001);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
